uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (8N1, optional 8E1) with a small byte FIFO
//
// Deserializes the asynchronous rx line into bytes and queues them behind a
// valid/ready interface. Framing and overrun errors pulse for one cycle.
//
// Build option: define UART_RX_PARITY_EN for 8E1 framing (even parity). This
// adds the PARITY state and the parity_err port.
//
// Ports:
//   clock      in   sole clock, rising edge
//   reset      in   asynchronous, active-high
//   rx         in   serial line, idle high, asynchronous to clock
//   data_out   out  [7:0] byte at FIFO head (0 when empty)
//   valid      out  FIFO non-empty
//   ready      in   consumer takes the head when valid && ready
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: byte dropped because FIFO full
//   parity_err out  one-cycle pulse: parity mismatch (UART_RX_PARITY_EN only)

module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // ---------------------------------------------------------------- signals
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          parity_err_q, parity_err_d;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          half_tick;
  logic          bit_tick;
  logic          push;
  logic          pop;
  logic          full;
  logic          do_push;

  // ------------------------------------------------------- synchronizer
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
  end

  assign half_tick = (cnt_q == HALF_LAST);
  assign bit_tick  = (cnt_q == BIT_LAST);

  // ------------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      // A start bit that is already high again at its midpoint was a glitch.
      S_START: if (half_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA: begin
        if (bit_tick && bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (bit_tick) state_d = S_STOP;
`endif
      S_STOP:  if (bit_tick) state_d = rx_s_q ? S_IDLE : S_BREAK;
      // Park here until the line is released so a held-low line reports once.
      S_BREAK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- FSM outputs
  // The counter restarts at every sample point, so after the half-bit start
  // sample each following sample lands a full bit later, i.e. at mid-bit.
  always_comb begin
    cnt_d        = cnt_q + CW'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    push         = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
      end
      S_START: begin
        if (half_tick) cnt_d = '0;
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d     = '0;
          par_bad_d = rx_s_q ^ (^shift_q);
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            push         = !par_bad_q;
            parity_err_d = par_bad_q;
`else
            push         = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // ------------------------------------------------------- FIFO
  assign valid    = (count_q != '0);
  assign data_out = valid ? mem_q[rd_ptr_q] : 8'h00;
  assign pop      = valid && ready;
  assign full     = (count_q == DEPTH_CNT);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || pop);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = push && full && !pop;
    if (do_push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // ------------------------------------------------------- state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
      mem_q        <= '{default: 8'h00};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo

module tb_uart_rx_fifo;

  localparam int C    = 16;
  localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Cycle at which the stop decision lands, counted from the cycle rx is
  // driven low: first edge seeing low, 2 sync edges, half bit, NB full bits.
  localparam int LAT = 1 + 2 + HALF + NB * C;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_fifo #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .FIFO_DEPTH(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic [7:0] got_q[$];
  int         pop_cyc[$];
  int         vcnt, fe_cnt, ovr_cnt, pe_cnt, first_v, ovr_cyc;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(valid), 1);
        chk("hold_data", int'(data_out), int'(prev_data));
      end
      if (valid) begin
        vcnt++;
        if (first_v < 0) first_v = cyc;
      end
      if (valid && ready) begin
        got_q.push_back(data_out);
        pop_cyc.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      if (overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
`ifdef UART_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
      prev_stall = valid && !ready;
      prev_data  = data_out;
    end
  end

  task automatic clr_mon();
    got_q.delete();
    pop_cyc.delete();
    vcnt    = 0;
    fe_cnt  = 0;
    ovr_cnt = 0;
    pe_cnt  = 0;
    first_v = -1;
    ovr_cyc = -1;
  endtask

  // ---------------------------------------------------------------- line driver
  // Invariant: every task is entered and left 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic pflip, output int t0);
    t0 = cyc;
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(d[i], C);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ pflip, C);
`endif
    hold(stop, C);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [7:0] exp_q[$];
  int         exp_fe;
  bit         done;

  initial begin
    int t0;
    int t5;
    logic [7:0] b;
    logic [7:0] d;

    clr_mon();
    reset = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_fe", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset = 1'b0;
    hold(1'b1, 5);

    // single clean frame, consumer always ready
    ready = 1'b1;
    clr_mon();
    send(8'hA5, 1'b1, 1'b0, t0);
    hold(1'b1, 20);
    chk("a5_vcnt", vcnt, 1);
    chk("a5_npop", got_q.size(), 1);
    if (got_q.size() > 0) chk("a5_data", int'(got_q[0]), 'hA5);
    chk("a5_time", first_v, t0 + LAT);
    chk("a5_fe", fe_cnt, 0);
    chk("a5_ovr", ovr_cnt, 0);

    // short low pulse is a glitch, receiver must still be ready to go
    clr_mon();
    hold(1'b0, 5);
    hold(1'b1, 40);
    chk("glitch_vcnt", vcnt, 0);
    chk("glitch_fe", fe_cnt, 0);
    send(8'h5A, 1'b1, 1'b0, t0);
    hold(1'b1, 20);
    chk("post_glitch_n", got_q.size(), 1);
    if (got_q.size() > 0) chk("post_glitch_data", int'(got_q[0]), 'h5A);
    chk("post_glitch_time", first_v, t0 + LAT);

    // bad stop bit followed by a held-low line
    clr_mon();
    send(8'h3C, 1'b0, 1'b0, t0);
    hold(1'b0, 40);
    hold(1'b1, 10);
    chk("brk_fe", fe_cnt, 1);
    chk("brk_vcnt", vcnt, 0);
    send(8'h81, 1'b1, 1'b0, t0);
    hold(1'b1, 20);
    chk("brk_next_n", got_q.size(), 1);
    if (got_q.size() > 0) chk("brk_next_data", int'(got_q[0]), 'h81);
    chk("brk_fe_total", fe_cnt, 1);

    // fill FIFO with ready low, fifth byte overruns
    ready = 1'b0;
    clr_mon();
    t5 = 0;
    for (int k = 1; k <= 5; k++) begin
      send(8'(k), 1'b1, 1'b0, t0);
      if (k == 5) t5 = t0;
    end
    hold(1'b1, 20);
    chk("ovr_cnt", ovr_cnt, 1);
    chk("ovr_time", ovr_cyc, t5 + LAT);
    chk("full_valid", int'(valid), 1);
    chk("full_head", int'(data_out), 1);
    ready = 1'b1;
    hold(1'b1, 10);
    chk("drain_n", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk($sformatf("drain_data%0d", i), int'(got_q[i]), i + 1);
      chk($sformatf("drain_cyc%0d", i), pop_cyc[i], pop_cyc[0] + i);
    end
    chk("drain_empty", int'(valid), 0);

    // reset in the middle of a frame with two bytes queued
    ready = 1'b0;
    clr_mon();
    send(8'h11, 1'b1, 1'b0, t0);
    send(8'h22, 1'b1, 1'b0, t0);
    b = 8'h77;
    hold(1'b0, C);
    for (int i = 0; i < 4; i++) hold(b[i], C);
    rx = b[4];
    repeat (HALF) @(posedge clock);
    #1;
    chk("pre_rst_valid", int'(valid), 1);
    chk("pre_rst_head", int'(data_out), 'h11);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_data", int'(data_out), 0);
    chk("mid_rst_fe", int'(frame_err), 0);
    chk("mid_rst_ovr", int'(overrun), 0);
    rx = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    hold(1'b1, 10);
    ready = 1'b1;
    clr_mon();
    send(8'h12, 1'b1, 1'b0, t0);
    hold(1'b1, 20);
    chk("post_rst_n", got_q.size(), 1);
    if (got_q.size() > 0) chk("post_rst_data", int'(got_q[0]), 'h12);
    chk("post_rst_time", first_v, t0 + LAT);

`ifdef UART_RX_PARITY_EN
    clr_mon();
    send(8'h07, 1'b1, 1'b0, t0);
    hold(1'b1, 20);
    chk("par_ok_n", got_q.size(), 1);
    if (got_q.size() > 0) chk("par_ok_data", int'(got_q[0]), 'h07);
    chk("par_ok_pe", pe_cnt, 0);
    clr_mon();
    send(8'h07, 1'b1, 1'b1, t0);
    hold(1'b1, 20);
    chk("par_bad_vcnt", vcnt, 0);
    chk("par_bad_pe", pe_cnt, 1);
    chk("par_bad_fe", fe_cnt, 0);
`endif

    // randomized frames against a queue model, consumer stalls at random
    clr_mon();
    exp_q.delete();
    exp_fe = 0;
    done   = 1'b0;
    fork
      begin
        for (int n = 0; n < 16; n++) begin
          int r;
          r = int'($urandom % 10);
          d = 8'($urandom);
          if (r < 7) begin
            send(d, 1'b1, 1'b0, t0);
            exp_q.push_back(d);
            hold(1'b1, int'($urandom % 8));
          end else if (r < 9) begin
            send(d, 1'b0, 1'b0, t0);
            exp_fe++;
            hold(1'b0, int'($urandom % 30));
            hold(1'b1, 1 + int'($urandom % 8));
          end else begin
            hold(1'b0, 1 + int'($urandom_range(0, 5)));
            hold(1'b1, 12 + int'($urandom % 8));
          end
        end
        hold(1'b1, 40);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1;
          ready = ($urandom % 4) != 0;
        end
      end
    join
    ready = 1'b1;
    hold(1'b1, 10);
    chk("rnd_n", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rnd_data%0d", i), int'(got_q[i]), int'(exp_q[i]));
    chk("rnd_fe", fe_cnt, exp_fe);
    chk("rnd_ovr", ovr_cnt, 0);
    chk("rnd_empty", int'(valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
